spi_xfer_seq: RTL and testbench



---
 rtl/spi_xfer_seq_pkg.sv | 30 +++
 rtl/spi_xfer_seq_if.sv | 21 ++
 rtl/spi_byte_ram.sv | 22 ++
 rtl/spi_xfer_seq.sv | 190 +++++++++++++++++++
 tb/tb_spi_xfer_seq.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_xfer_seq_pkg.sv
// rtl/spi_xfer_seq_pkg.sv - shared state encoding, timing defaults and helpers for spi_xfer_seq
package spi_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    localparam int DEF_MAX_LEN  = 16;
    localparam int DEF_CS_SETUP = 4;
    localparam int DEF_CS_HOLD  = 4;
    localparam int DEF_CS_GAP   = 4;
    localparam int DEF_TIMEOUT  = 255;

    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_xfer_seq_if.sv
// rtl/spi_xfer_seq_if.sv - handshake between the transfer sequencer and the SPI byte engine
interface spi_xfer_seq_if;
    logic       eng_tx_begin;
    logic [7:0] eng_tx_data;
    logic       eng_tx_end;
    logic [7:0] eng_rx_data;

    modport master (
        output eng_tx_begin,
        output eng_tx_data,
        input  eng_tx_end,
        input  eng_rx_data
    );

    modport slave (
        input  eng_tx_begin,
        input  eng_tx_data,
        output eng_tx_end,
        output eng_rx_data
    );
endinterface

// File: rtl/spi_byte_ram.sv
// rtl/spi_byte_ram.sv - byte register array, one synchronous write port and one async read port
module spi_byte_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/spi_xfer_seq.sv
// rtl/spi_xfer_seq.sv - frames N-byte SPI transfers under one chip select around a byte engine
module spi_xfer_seq
    import spi_pkg::*;
#(
    parameter int MAX_LEN  = DEF_MAX_LEN,
    parameter int CS_SETUP = DEF_CS_SETUP,
    parameter int CS_HOLD  = DEF_CS_HOLD,
    parameter int CS_GAP   = DEF_CS_GAP,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    localparam int AW      = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   xfer_len,
    input  logic          txb_we,
    input  logic [AW-1:0] txb_addr,
    input  logic [7:0]    txb_wdata,
    input  logic [AW-1:0] rxb_addr,
    output logic [7:0]    rxb_rdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          cs_n,
    spi_xfer_seq_if.master eng
);
    localparam int CNT_MAX = max_of4(CS_SETUP, CS_HOLD, CS_GAP, TIMEOUT);
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW:0]   idx_q, idx_d;
    logic [AW:0]   len_q, len_d;
    logic          cs_n_q, cs_n_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          tx_begin_q, tx_begin_d;
    logic [7:0]    tx_data_q, tx_data_d;

    logic [AW:0]   len_clamped;
    logic [7:0]    tx_rdata;
    logic          tx_we;
    logic          rx_we;

    assign len_clamped = (AW+1)'(clamp_len(int'(xfer_len), MAX_LEN));
    assign tx_we       = txb_we && (state_q == ST_IDLE) && !rst;
    assign rx_we       = eng.eng_tx_end && (state_q == ST_WAIT) && !rst;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        len_d      = len_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        tx_begin_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_clamped != '0) begin
                        state_d = ST_SETUP;
                        cs_n_d  = 1'b0;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                        len_d   = len_clamped;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == CW'(CS_SETUP - 1)) begin
                    state_d    = ST_ISSUE;
                    cnt_d      = '0;
                    tx_begin_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (eng.eng_tx_end) begin
                    idx_d = idx_q + 1'b1;
                    cnt_d = '0;
                    if (idx_q + 1'b1 == len_q) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d    = ST_ISSUE;
                        tx_begin_d = 1'b1;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CW'(CS_HOLD - 1)) begin
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == CW'(CS_GAP - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The byte is fetched at the index the FSM is about to issue, so it is stable while tx_begin is high.
    always_comb begin
        tx_data_d = tx_data_q;
        if (tx_begin_d) begin
            tx_data_d = tx_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tx_begin_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tx_begin_q <= tx_begin_d;
            tx_data_q  <= tx_data_d;
        end
    end

    spi_byte_ram #(.DEPTH(MAX_LEN), .AW(AW)) u_tx_ram (
        .clk   (clk),
        .we    (tx_we),
        .waddr (txb_addr),
        .wdata (txb_wdata),
        .raddr (idx_d[AW-1:0]),
        .rdata (tx_rdata)
    );

    spi_byte_ram #(.DEPTH(MAX_LEN), .AW(AW)) u_rx_ram (
        .clk   (clk),
        .we    (rx_we),
        .waddr (idx_q[AW-1:0]),
        .wdata (eng.eng_rx_data),
        .raddr (rxb_addr),
        .rdata (rxb_rdata)
    );

    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;
    assign cs_n             = cs_n_q;
    assign eng.eng_tx_begin = tx_begin_q;
    assign eng.eng_tx_data  = tx_data_q;
endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb/tb_spi_xfer_seq.sv - scoreboard bench for spi_xfer_seq with a loopback byte engine model
module tb_spi_xfer_seq;
    localparam int AW      = 4;
    localparam int K_BEGIN = 0;
    localparam int K_DONE  = 1;

    typedef struct {
        int kind;
        int val;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   xfer_len;
    logic          txb_we;
    logic [AW-1:0] txb_addr;
    logic [7:0]    txb_wdata;
    logic [AW-1:0] rxb_addr;
    logic [7:0]    rxb_rdata;
    logic          busy, done, err, cs_n;

    spi_xfer_seq_if eng_if();

    spi_xfer_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .xfer_len  (xfer_len),
        .txb_we    (txb_we),
        .txb_addr  (txb_addr),
        .txb_wdata (txb_wdata),
        .rxb_addr  (rxb_addr),
        .rxb_rdata (rxb_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cs_n      (cs_n),
        .eng       (eng_if.master)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    logic       eng_silent = 1'b0;
    logic [7:0] eng_mask   = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic push(input int kind, input int val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Engine model: answers each tx_begin two cycles later with a one-cycle tx_end.
    initial begin
        logic [7:0] d;
        eng_if.eng_tx_end  = 1'b0;
        eng_if.eng_rx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (eng_if.eng_tx_begin && !eng_silent) begin
                d = eng_if.eng_tx_data;
                @(posedge clk);
                @(posedge clk);
                #1;
                eng_if.eng_tx_end  = 1'b1;
                eng_if.eng_rx_data = d ^ eng_mask;
                @(posedge clk);
                #1;
                eng_if.eng_tx_end  = 1'b0;
            end
        end
    end

    exp_t mon_e;
    int   low_cnt = 0, hold_cnt = 0, gap_cnt = 0;
    bit   first_seen = 1'b0, hold_arm = 1'b0, gap_arm = 1'b0;
    bit   rst_prev = 1'b1, cs_prev = 1'b1;

    always @(negedge clk) begin
        if (eng_if.eng_tx_begin) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL begin_unexpected actual data=%0h required=no tx_begin", eng_if.eng_tx_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.kind != K_BEGIN) begin
                    errors++;
                    $display("FAIL begin_order actual=tx_begin required kind=%0d", mon_e.kind);
                end else begin
                    chk("tx_data", 32'(eng_if.eng_tx_data), 32'(mon_e.val));
                end
            end
        end
        if (done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected actual=1 required=0");
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.kind != K_DONE) begin
                    errors++;
                    $display("FAIL done_order actual=done required kind=%0d", mon_e.kind);
                end else begin
                    chk("done_err", 32'(err), 32'(mon_e.val));
                    chk("done_cs_n", 32'(cs_n), 32'd1);
                end
            end
        end
        if (cs_n) begin
            low_cnt    = 0;
            first_seen = 1'b0;
        end else if (!first_seen) begin
            if (eng_if.eng_tx_begin) begin
                chk("cs_setup", 32'(low_cnt), 32'd4);
                first_seen = 1'b1;
            end else begin
                low_cnt++;
            end
        end
        if (eng_if.eng_tx_begin) hold_arm = 1'b0;
        if (eng_if.eng_tx_end) begin
            hold_arm = 1'b1;
            hold_cnt = 0;
        end else if (hold_arm && !cs_n) begin
            hold_cnt++;
        end
        if (cs_n && !cs_prev) begin
            if (hold_arm && !rst_prev) chk("cs_hold", 32'(hold_cnt), 32'd4);
            hold_arm = 1'b0;
            if (!rst_prev) begin
                gap_arm = 1'b1;
                gap_cnt = 0;
            end
        end
        if (gap_arm) begin
            if (busy) begin
                gap_cnt++;
            end else begin
                chk("cs_gap", 32'(gap_cnt), 32'd4);
                gap_arm = 1'b0;
            end
        end
        if (rst) begin
            hold_arm = 1'b0;
            gap_arm  = 1'b0;
        end
        rst_prev = rst;
        cs_prev  = cs_n;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input int d);
        txb_we    = 1'b1;
        txb_addr  = AW'(a);
        txb_wdata = 8'(d);
        tick();
        txb_we    = 1'b0;
    endtask

    task automatic do_start(input int len);
        xfer_len = (AW+1)'(len);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s_timeout actual busy=1 required busy=0", name);
        end
        tick();
        chk({name, "_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_rx(input int a, input int expv);
        rxb_addr = AW'(a);
        #1;
        chk("rx_data", 32'(rxb_rdata), 32'(expv));
    endtask

    initial begin
        int n, m, c;
        logic [7:0] tbl [16];
        rst = 1'b1; start = 1'b0; xfer_len = '0; txb_we = 1'b0;
        txb_addr = '0; txb_wdata = '0; rxb_addr = '0;
        repeat (3) tick();
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_begin", 32'(eng_if.eng_tx_begin), 32'd0);
        chk("rst_data", 32'(eng_if.eng_tx_data), 32'd0);
        rst = 1'b0;
        tick();

        // Three-byte loopback; byte 0 is written on the same edge start is taken.
        load(0, 8'h00); load(1, 8'h3C); load(2, 8'hFF);
        push(K_BEGIN, 8'hA5); push(K_BEGIN, 8'h3C); push(K_BEGIN, 8'hFF); push(K_DONE, 0);
        txb_we = 1'b1; txb_addr = 0; txb_wdata = 8'hA5;
        do_start(3);
        txb_we = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_cs_n", 32'(cs_n), 32'd0);
        wait_idle("xfer3");
        chk_rx(0, 8'hA5); chk_rx(1, 8'h3C); chk_rx(2, 8'hFF);

        // Zero-length request only pulses done.
        push(K_DONE, 0);
        do_start(0);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_cs_n", 32'(cs_n), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        tick();
        chk("len0_done_clear", 32'(done), 32'd0);
        chk("len0_busy_after", 32'(busy), 32'd0);

        // Oversized length clamps to the full buffer.
        eng_mask = 8'h5A;
        for (int i = 0; i < 16; i++) begin
            tbl[i] = 8'((i * 13 + 7) & 8'hFF);
            load(i, tbl[i]);
            push(K_BEGIN, tbl[i]);
        end
        push(K_DONE, 0);
        do_start(20);
        wait_idle("xfer20");
        chk_rx(0, tbl[0] ^ 8'h5A);
        chk_rx(15, tbl[15] ^ 8'h5A);
        eng_mask = 8'h00;

        // Silent engine on the first of two bytes.
        eng_silent = 1'b1;
        load(0, 8'hC3);
        push(K_BEGIN, 8'hC3); push(K_DONE, 1);
        do_start(2);
        n = 0;
        while (!eng_if.eng_tx_begin && n < 50) begin
            tick();
            n++;
        end
        m = 0;
        while (!err && m < 400) begin
            tick();
            m++;
        end
        chk("timeout_cycles", 32'(m), 32'd256);
        chk("timeout_cs_n_hold", 32'(cs_n), 32'd0);
        wait_idle("timeout");
        chk("err_sticky", 32'(err), 32'd1);
        eng_silent = 1'b0;
        push(K_BEGIN, 8'hC3); push(K_DONE, 0);
        do_start(1);
        chk("err_cleared", 32'(err), 32'd0);
        wait_idle("after_timeout");

        // Reset two cycles after the second tx_begin.
        load(0, 8'h11); load(1, 8'h22); load(2, 8'h33);
        push(K_BEGIN, 8'h11); push(K_BEGIN, 8'h22);
        do_start(3);
        c = 0; n = 0;
        while (c < 2 && n < 100) begin
            if (eng_if.eng_tx_begin) c++;
            if (c < 2) begin
                tick();
                n++;
            end
        end
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_cs_n", 32'(cs_n), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_begin", 32'(eng_if.eng_tx_begin), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        repeat (8) tick();
        chk("midrst_queue", 32'(exp_q.size()), 32'd0);

        // start and txb_we held during busy are ignored; start lands on the first idle cycle.
        push(K_BEGIN, 8'h11); push(K_BEGIN, 8'h22); push(K_DONE, 0);
        push(K_BEGIN, 8'h11); push(K_DONE, 0);
        do_start(2);
        start = 1'b1; xfer_len = 1;
        txb_we = 1'b1; txb_addr = 1; txb_wdata = 8'hEE;
        repeat (8) tick();
        txb_we = 1'b0;
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        chk("held_start_idle", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        chk("held_start_taken", 32'(busy), 32'd1);
        wait_idle("held_start");
        chk_rx(1, 8'h22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end
endmodule
